// File: rtl/b13_serial_rx.sv
// rtl/b13_serial_rx.sv - strobe-timed serial frame receiver with one-entry holding buffer
module b13_serial_rx #(
  parameter int BIT_PERIOD = 106,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic       dsr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rd_ack,
  output logic       rx_busy,
  output logic       frame_error,
  output logic       overrun,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_error;
  logic             r_overrun;

  logic             w_cnt_done;
  logic             w_stop_edge;
  logic             w_good_stop;
  logic             w_bad_stop;
  logic             w_deliver;
  logic             w_drop;

  // State register; a start strobe is simply a 0 seen while idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and sample-edge decode; every sample lands on the last count of a bit period.
  always_comb begin
    w_state_next = r_state;
    w_cnt_done   = (r_cnt == CNT_LAST);
    w_stop_edge  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rx_in) w_state_next = DATA;
      end
      DATA: begin
        if (w_cnt_done && (r_bit_idx == 3'd7)) w_state_next = STOP;
      end
      STOP: begin
        w_stop_edge = w_cnt_done;
        if (w_cnt_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    w_good_stop = w_stop_edge & rx_in;
    w_bad_stop  = w_stop_edge & ~rx_in;
    // A pop on the same edge frees the buffer for the incoming byte.
    w_deliver   = w_good_stop & (~r_rx_valid | rd_ack);
    w_drop      = w_good_stop & r_rx_valid & ~rd_ack;
  end

  // Bit timing and byte assembly; the counter restarts at every sample so it never wraps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else if (r_state == IDLE) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
    end else if (w_cnt_done) begin
      r_cnt <= '0;
      if (r_state == DATA) begin
        r_shift   <= {r_shift[6:0], rx_in};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Holding buffer and sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_deliver) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (rd_ack && r_rx_valid) begin
        r_rx_valid <= 1'b0;
      end
      if (w_bad_stop)   r_frame_error <= 1'b1;
      else if (err_clr) r_frame_error <= 1'b0;
      if (w_drop)       r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign dsr         = ~r_rx_valid;
  assign rx_busy     = (r_state != IDLE);
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_b13_serial_rx.sv
// tb/tb_b13_serial_rx.sv - randomized self-checking bench for b13_serial_rx
module tb_b13_serial_rx;

  localparam int BP = 106;

  logic       clock;
  logic       reset_n;
  logic       rx_in;
  logic       dsr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_ack;
  logic       rx_busy;
  logic       frame_error;
  logic       overrun;
  logic       err_clr;

  int checks;
  int errors;
  int busy_bad;

  // Behavioural view of the receiver: what the consumer should see.
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ferr;
  logic       m_ovr;

  b13_serial_rx #(.BIT_PERIOD(BP), .CNT_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_in       (rx_in),
    .dsr         (dsr),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rd_ack      (rd_ack),
    .rx_busy     (rx_busy),
    .frame_error (frame_error),
    .overrun     (overrun),
    .err_clr     (err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Outcome of a whole frame at its stop edge, from the frame-level rules.
  task automatic model_stop(input logic [7:0] b, input bit stop, input bit ack, input bit clr);
    if (clr) begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    if (!stop) begin
      m_ferr = 1'b1;
      if (ack) m_valid = 1'b0;
    end else if (!m_valid || ack) begin
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  // Drives ten strobes BP apart; abort_at >= 0 pulses reset at edge T0+abort_at.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit ack,
                            input bit clr, input int abort_at);
    logic [9:0] v;
    v[0] = 1'b0;
    for (int k = 1; k <= 8; k++) v[k] = b[8-k];
    v[9] = stop;
    busy_bad = 0;
    for (int c = 0; c <= 9*BP; c++) begin
      if (c == abort_at) begin
        reset_n = 1'b0;
        rx_in   = 1'b1;
        tick();
        reset_n = 1'b1;
        model_reset();
        return;
      end
      rx_in = ((c % BP) == 0) ? v[c / BP] : 1'b1;
      if (c == 9*BP) begin
        rd_ack  = ack;
        err_clr = clr;
      end
      tick();
      rd_ack  = 1'b0;
      err_clr = 1'b0;
      if (rx_busy !== (c < 9*BP)) busy_bad++;
    end
    rx_in = 1'b1;
    model_stop(b, stop, ack, clr);
  endtask

  task automatic pop();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic test_reset();
    rx_in   = 1'b1;
    rd_ack  = 1'b0;
    err_clr = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    model_reset();
    checks++;
    if ({rx_valid, rx_busy, frame_error, overrun, dsr, rx_data} !== {5'b00001, 8'h00}) begin
      $display("FAIL reset_outputs: got valid=%b busy=%b ferr=%b ovr=%b dsr=%b data=%h required 0,0,0,0,1,00",
               rx_valid, rx_busy, frame_error, overrun, dsr, rx_data);
      errors++;
    end
    repeat (5) tick();
    checks++;
    if (rx_busy !== 1'b0) begin
      $display("FAIL reset_idle: got busy=%b required 0", rx_busy);
      errors++;
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
    checks++;
    if ({rx_valid, rx_data, dsr, frame_error} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
      $display("FAIL good_frame: got valid=%b data=%h dsr=%b ferr=%b required 1,a5,0,0",
               rx_valid, rx_data, dsr, frame_error);
      errors++;
    end
    checks++;
    if (busy_bad != 0) begin
      $display("FAIL good_frame_busy: got %0d wrong busy samples required 0", busy_bad);
      errors++;
    end
    pop();
    checks++;
    if ({rx_valid, dsr} !== 2'b01) begin
      $display("FAIL pop: got valid=%b dsr=%b required 0,1", rx_valid, dsr);
      errors++;
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    checks++;
    if ({frame_error, rx_valid} !== 2'b10) begin
      $display("FAIL frame_error_set: got ferr=%b valid=%b required 1,0", frame_error, rx_valid);
      errors++;
    end
    clear_errors();
    checks++;
    if (frame_error !== 1'b0) begin
      $display("FAIL frame_error_clr: got %b required 0", frame_error);
      errors++;
    end
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1);
    checks++;
    if ({rx_valid, rx_data, frame_error} !== {1'b1, 8'hFF, 1'b0}) begin
      $display("FAIL after_error_frame: got valid=%b data=%h ferr=%b required 1,ff,0",
               rx_valid, rx_data, frame_error);
      errors++;
    end
    pop();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
    checks++;
    if ({rx_data, rx_valid, overrun} !== {8'h11, 1'b1, 1'b1}) begin
      $display("FAIL overrun_set: got data=%h valid=%b ovr=%b required 11,1,1", rx_data, rx_valid, overrun);
      errors++;
    end
    clear_errors();
    pop();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, -1);
    checks++;
    if ({rx_data, rx_valid, overrun} !== {8'h22, 1'b1, 1'b0}) begin
      $display("FAIL ack_on_stop: got data=%h valid=%b ovr=%b required 22,1,0", rx_data, rx_valid, overrun);
      errors++;
    end
    pop();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 500);
    checks++;
    if ({rx_busy, rx_valid, frame_error, overrun} !== 4'b0000) begin
      $display("FAIL mid_reset: got busy=%b valid=%b ferr=%b ovr=%b required 0000",
               rx_busy, rx_valid, frame_error, overrun);
      errors++;
    end
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
    checks++;
    if ({rx_valid, rx_data, frame_error} !== {1'b1, 8'h81, 1'b0}) begin
      $display("FAIL after_mid_reset: got valid=%b data=%h ferr=%b required 1,81,0",
               rx_valid, rx_data, frame_error);
      errors++;
    end
    pop();
  endtask

  task automatic test_idle_line();
    int bad;
    bad = 0;
    rx_in = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (rx_busy !== 1'b0 || rx_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL idle_line: got %0d cycles busy or valid required 0", bad);
      errors++;
    end
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, -1);
    checks++;
    if ({rx_valid, rx_data, frame_error} !== {1'b1, 8'h00, 1'b0}) begin
      $display("FAIL zero_frame: got valid=%b data=%h ferr=%b required 1,00,0",
               rx_valid, rx_data, frame_error);
      errors++;
    end
    pop();
  endtask

  // Random frames, back to back or with short gaps, with random acks, clears and bad stops.
  task automatic test_random();
    logic [7:0] b;
    bit stop, ack, clr;
    for (int i = 0; i < 9; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      ack  = ($urandom_range(0, 1) == 1);
      clr  = ($urandom_range(0, 2) == 0);
      send_frame(b, stop, ack, clr, -1);
      checks++;
      if ({rx_valid, dsr, frame_error, overrun} !== {m_valid, ~m_valid, m_ferr, m_ovr}) begin
        $display("FAIL random_flags[%0d]: got valid=%b dsr=%b ferr=%b ovr=%b required %b,%b,%b,%b",
                 i, rx_valid, dsr, frame_error, overrun, m_valid, ~m_valid, m_ferr, m_ovr);
        errors++;
      end
      if (m_valid) begin
        checks++;
        if (rx_data !== m_data) begin
          $display("FAIL random_data[%0d]: got %h required %h", i, rx_data, m_data);
          errors++;
        end
      end
      checks++;
      if (busy_bad != 0) begin
        $display("FAIL random_busy[%0d]: got %0d wrong busy samples required 0", i, busy_bad);
        errors++;
      end
      if ($urandom_range(0, 2) == 0) pop();
      repeat ($urandom_range(0, 12)) tick();
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    busy_bad = 0;
    rx_in    = 1'b1;
    rd_ack   = 1'b0;
    err_clr  = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    test_reset();
    test_good_frame();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_idle_line();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
